// File: rtl/mmul2_pkg.sv
// Shared types for the mmul2 loop-nest controller: state encoding and index width.
package mmul2_pkg;
    localparam int IDX_W = 32;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/mmul2_idx_counter.sv
// Wrap counter 0..LIMIT-1 with synchronous clear (priority) and enable; last flags LIMIT-1.
// Registered count, combinational last; no backpressure of its own.
module mmul2_idx_counter
    import mmul2_pkg::*;
#(
    parameter idx_t LIMIT = idx_t'(1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output idx_t cnt,
    output logic last
);
    idx_t cnt_q;
    idx_t cnt_d;

    assign last = (cnt_q == (LIMIT - idx_t'(1)));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + idx_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mmul2_sequencer.sv
// Loop-nest controller for C = A*B: walks i/j/k, drives MAC addresses/control, one WB cycle per element.
// Operands one cycle after start; stall freezes RUN only, WB and DONE are single fixed cycles.
module mmul2_sequencer
    import mmul2_pkg::*;
#(
    parameter int unsigned RA = 0,
    parameter int unsigned CA = 0,
    parameter int unsigned RB = 0,
    parameter int unsigned CB = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    output logic [31:0] i,
    output logic [31:0] j,
    output logic [31:0] k,
    output logic [31:0] a_addr,
    output logic [31:0] b_addr,
    output logic [31:0] c_addr,
    output logic        valid,
    output logic        acc_clr,
    output logic        c_we,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam idx_t CA_I   = idx_t'(CA);
    localparam idx_t CB_I   = idx_t'(CB);
    localparam bit   CFG_OK = (CA == RB) && (RA != 0) && (CA != 0) && (CB != 0);

    localparam logic [63:0] P_AC = 64'(RA) * 64'(CA);
    localparam logic [63:0] P_CB = 64'(CA) * 64'(CB);
    localparam logic [63:0] P_RB = 64'(RA) * 64'(CB);

    if ((P_AC > 64'hFFFF_FFFF) || (P_CB > 64'hFFFF_FFFF) || (P_RB > 64'hFFFF_FFFF)) begin : g_size_chk
        $error("mmul2_sequencer: matrix dimension products exceed 32 bits");
    end

    state_t state_q, state_d;
    idx_t   a_q, a_d, b_q, b_d, c_q, c_d, row_q, row_d;
    logic   valid_q, valid_d, acc_clr_q, acc_clr_d, c_we_q, c_we_d;
    logic   busy_q, busy_d, done_q, done_d, err_q, err_d;

    idx_t   i_cnt, j_cnt, k_cnt;
    logic   i_last, j_last, k_last;
    logic   start_acc, in_run, in_wb;

    assign start_acc = (state_q == IDLE) && start;
    assign in_run    = (state_q == RUN);
    assign in_wb     = (state_q == WB);

    // k stays on CA-1 through WB so the write-back cycle still shows the last operand pair.
    mmul2_idx_counter #(.LIMIT(CA_I)) u_k (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start_acc | in_wb),
        .en   (in_run && !stall && !k_last),
        .cnt  (k_cnt),
        .last (k_last)
    );

    mmul2_idx_counter #(.LIMIT(CB_I)) u_j (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start_acc | (in_wb && j_last)),
        .en   (in_wb && !j_last),
        .cnt  (j_cnt),
        .last (j_last)
    );

    mmul2_idx_counter #(.LIMIT(idx_t'(RA))) u_i (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start_acc),
        .en   (in_wb && j_last && !i_last),
        .cnt  (i_cnt),
        .last (i_last)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        row_d     = row_q;
        valid_d   = valid_q;
        acc_clr_d = acc_clr_q;
        c_we_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    a_d    = '0;
                    b_d    = '0;
                    c_d    = '0;
                    row_d  = '0;
                    if (CFG_OK) begin
                        state_d   = RUN;
                        valid_d   = 1'b1;
                        acc_clr_d = 1'b1;
                        err_d     = 1'b0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    acc_clr_d = 1'b0;
                    if (!k_last) begin
                        a_d = a_q + idx_t'(1);
                        b_d = b_q + CB_I;
                    end else begin
                        state_d = WB;
                        valid_d = 1'b0;
                        c_we_d  = 1'b1;
                    end
                end
            end
            WB: begin
                if (!j_last) begin
                    state_d   = RUN;
                    valid_d   = 1'b1;
                    acc_clr_d = 1'b1;
                    a_d       = row_q;
                    b_d       = j_cnt + idx_t'(1);
                    c_d       = c_q + idx_t'(1);
                end else if (!i_last) begin
                    state_d   = RUN;
                    valid_d   = 1'b1;
                    acc_clr_d = 1'b1;
                    row_d     = row_q + CA_I;
                    a_d       = row_q + CA_I;
                    b_d       = '0;
                    c_d       = c_q + idx_t'(1);
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            acc_clr_q <= 1'b0;
            c_we_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            row_q     <= row_d;
            valid_q   <= valid_d;
            acc_clr_q <= acc_clr_d;
            c_we_q    <= c_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign i       = i_cnt;
    assign j       = j_cnt;
    assign k       = k_cnt;
    assign a_addr  = a_q;
    assign b_addr  = b_q;
    assign c_addr  = c_q;
    assign valid   = valid_q;
    assign acc_clr = acc_clr_q;
    assign c_we    = c_we_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
endmodule

// File: tb/tb_mmul2_sequencer.sv
// Bench for mmul2_sequencer: three configurations (2x3*3x2, bad 3/2 inner dims, 1x1*1x1)
// checked cycle by cycle against an i/j/k loop-nest reference with stall-aware replay.
module tb_mmul2_sequencer;
    localparam int RA = 2, CA = 3, CB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        g_start = 0, g_stall = 0;
    logic [31:0] g_i, g_j, g_k, g_a, g_b, g_c;
    logic        g_valid, g_clr, g_we, g_busy, g_done, g_err;

    logic        e_start = 0, e_stall = 0;
    logic [31:0] e_i, e_j, e_k, e_a, e_b, e_c;
    logic        e_valid, e_clr, e_we, e_busy, e_done, e_err;

    logic        o_start = 0, o_stall = 0;
    logic [31:0] o_i, o_j, o_k, o_a, o_b, o_c;
    logic        o_valid, o_clr, o_we, o_busy, o_done, o_err;

    mmul2_sequencer #(.RA(RA), .CA(CA), .RB(CA), .CB(CB)) u_big (
        .clk(clk), .rst_n(rst_n), .start(g_start), .stall(g_stall),
        .i(g_i), .j(g_j), .k(g_k), .a_addr(g_a), .b_addr(g_b), .c_addr(g_c),
        .valid(g_valid), .acc_clr(g_clr), .c_we(g_we), .busy(g_busy), .done(g_done), .err(g_err)
    );

    mmul2_sequencer #(.RA(2), .CA(3), .RB(2), .CB(2)) u_bad (
        .clk(clk), .rst_n(rst_n), .start(e_start), .stall(e_stall),
        .i(e_i), .j(e_j), .k(e_k), .a_addr(e_a), .b_addr(e_b), .c_addr(e_c),
        .valid(e_valid), .acc_clr(e_clr), .c_we(e_we), .busy(e_busy), .done(e_done), .err(e_err)
    );

    mmul2_sequencer #(.RA(1), .CA(1), .RB(1), .CB(1)) u_one (
        .clk(clk), .rst_n(rst_n), .start(o_start), .stall(o_stall),
        .i(o_i), .j(o_j), .k(o_k), .a_addr(o_a), .b_addr(o_b), .c_addr(o_c),
        .valid(o_valid), .acc_clr(o_clr), .c_we(o_we), .busy(o_busy), .done(o_done), .err(o_err)
    );

    typedef struct {
        bit v;
        bit clr;
        bit we;
        bit dn;
        int i;
        int j;
        int k;
    } ev_t;

    ev_t exp_q[$];

    task automatic build_big();
        ev_t e;
        exp_q.delete();
        for (int ii = 0; ii < RA; ii++) begin
            for (int jj = 0; jj < CB; jj++) begin
                for (int kk = 0; kk < CA; kk++) begin
                    e = '{v: 1, clr: (kk == 0), we: 0, dn: 0, i: ii, j: jj, k: kk};
                    exp_q.push_back(e);
                end
                e = '{v: 0, clr: 0, we: 1, dn: 0, i: ii, j: jj, k: CA - 1};
                exp_q.push_back(e);
            end
        end
        e = '{v: 0, clr: 0, we: 0, dn: 1, i: 0, j: 0, k: 0};
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({g_valid, g_clr, g_we, g_busy, g_done, g_err} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {g_valid, g_clr, g_we, g_busy, g_done, g_err});
        end
        n_checks++;
        if ({g_i, g_j, g_k, g_a, g_b, g_c} !== 192'b0) begin
            n_errors++;
            $display("FAIL reset_idx: got i%0d j%0d k%0d a%0d b%0d c%0d want all 0", g_i, g_j, g_k, g_a, g_b, g_c);
        end
        n_checks++;
        if ({e_err, e_busy, o_err, o_busy} !== 4'b0) begin
            n_errors++;
            $display("FAIL reset_others: got %b want 0000", {e_err, e_busy, o_err, o_busy});
        end
        rst_n = 1'b1;
    endtask

    // mode 0: no stall, 1: stall twice at (1,0,k=1), 2: random stall with start held
    task automatic test_mult_run(input int mode);
        ev_t e;
        int  p = 0, nst = 0, nwe = 0, fixed_left = 2;
        bit  fin = 0, st;
        build_big();
        @(negedge clk);
        g_start = 1'b1;
        g_stall = 1'b0;
        for (int cyc = 1; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            if (mode != 2) g_start = 1'b0;
            e = exp_q[p];
            if (g_we) nwe++;
            n_checks++;
            if ({g_valid, g_clr, g_we, g_done, g_busy} !== {e.v, e.clr, e.we, e.dn, 1'b1}) begin
                n_errors++;
                $display("FAIL run%0d_ctrl cyc%0d: got v/clr/we/done/busy=%b want %b", mode, cyc,
                         {g_valid, g_clr, g_we, g_done, g_busy}, {e.v, e.clr, e.we, e.dn, 1'b1});
            end
            if (e.v || e.we) begin
                n_checks++;
                if (g_i !== 32'(e.i) || g_j !== 32'(e.j) || g_k !== 32'(e.k) ||
                    g_a !== 32'(e.i * CA + e.k) || g_b !== 32'(e.k * CB + e.j) ||
                    g_c !== 32'(e.i * CB + e.j)) begin
                    n_errors++;
                    $display("FAIL run%0d_idx cyc%0d: got i%0d j%0d k%0d a%0d b%0d c%0d want i%0d j%0d k%0d a%0d b%0d c%0d",
                             mode, cyc, g_i, g_j, g_k, g_a, g_b, g_c, e.i, e.j, e.k,
                             e.i * CA + e.k, e.k * CB + e.j, e.i * CB + e.j);
                end
            end
            if (e.dn) begin
                fin = 1'b1;
                g_start = 1'b0;
                g_stall = 1'b0;
                n_checks++;
                if (cyc != RA * CB * (CA + 1) + 1 + nst) begin
                    n_errors++;
                    $display("FAIL run%0d_total: done at cycle %0d want %0d", mode, cyc, RA * CB * (CA + 1) + 1 + nst);
                end
            end else begin
                case (mode)
                    1:       st = e.v && e.i == 1 && e.j == 0 && e.k == 1 && fixed_left > 0;
                    2:       st = ($urandom_range(0, 2) == 0);
                    default: st = 1'b0;
                endcase
                if (mode == 1 && st) fixed_left--;
                g_stall = st;
                if (e.v && st) nst++;
                else p++;
            end
        end
        n_checks++;
        if (!fin) begin
            n_errors++;
            $display("FAIL run%0d_timeout: done not seen, got %0d want 1", mode, fin);
        end
        n_checks++;
        if (nwe != RA * CB || (mode == 1 && nst != 2)) begin
            n_errors++;
            $display("FAIL run%0d_counts: c_we %0d stalls %0d want c_we %0d", mode, nwe, nst, RA * CB);
        end
        g_stall = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_checks++;
            if ({g_busy, g_done, g_valid, g_we, g_err} !== 5'b0) begin
                n_errors++;
                $display("FAIL run%0d_idle +%0d: got busy/done/v/we/err=%b want 00000", mode, n,
                         {g_busy, g_done, g_valid, g_we, g_err});
            end
        end
    endtask

    task automatic test_bad_cfg();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            e_start = 1'b1;
            @(negedge clk);
            e_start = 1'b0;
            n_checks++;
            if ({e_done, e_err, e_busy, e_valid, e_we} !== 5'b11100) begin
                n_errors++;
                $display("FAIL bad%0d_done: got done/err/busy/v/we=%b want 11100", r, {e_done, e_err, e_busy, e_valid, e_we});
            end
            for (int n = 0; n < 2; n++) begin
                @(negedge clk);
                n_checks++;
                if ({e_done, e_err, e_busy, e_valid, e_we} !== 5'b01000) begin
                    n_errors++;
                    $display("FAIL bad%0d_after%0d: got done/err/busy/v/we=%b want 01000", r, n,
                             {e_done, e_err, e_busy, e_valid, e_we});
                end
            end
        end
    endtask

    task automatic test_one();
        @(negedge clk);
        o_start = 1'b1;
        @(negedge clk);
        o_start = 1'b0;
        n_checks++;
        if ({o_valid, o_clr, o_we, o_done} !== 4'b1100 || o_a !== 32'd0 || o_b !== 32'd0) begin
            n_errors++;
            $display("FAIL one_mac: got v/clr/we/done=%b a%0d b%0d want 1100 a0 b0", {o_valid, o_clr, o_we, o_done}, o_a, o_b);
        end
        @(negedge clk);
        n_checks++;
        if ({o_valid, o_we, o_done} !== 3'b010 || o_c !== 32'd0) begin
            n_errors++;
            $display("FAIL one_wb: got v/we/done=%b c%0d want 010 c0", {o_valid, o_we, o_done}, o_c);
        end
        @(negedge clk);
        n_checks++;
        if ({o_valid, o_we, o_done, o_busy, o_err} !== 5'b00110) begin
            n_errors++;
            $display("FAIL one_done: got v/we/done/busy/err=%b want 00110", {o_valid, o_we, o_done, o_busy, o_err});
        end
        @(negedge clk);
        n_checks++;
        if ({o_done, o_busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL one_idle: got done/busy=%b want 00", {o_done, o_busy});
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        @(negedge clk);
        g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        for (int n = 0; n < 50 && !hit; n++) begin
            if (g_we && g_i == 32'd0 && g_j == 32'd1) hit = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL mid_reach: WB of (0,1) not seen, got %0d want 1", hit);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({g_valid, g_clr, g_we, g_busy, g_done} !== 5'b0 || {g_i, g_j, g_k, g_a, g_b, g_c} !== 192'b0) begin
            n_errors++;
            $display("FAIL mid_clear: got ctrl %b i%0d j%0d k%0d a%0d b%0d c%0d want all 0",
                     {g_valid, g_clr, g_we, g_busy, g_done}, g_i, g_j, g_k, g_a, g_b, g_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_checks++;
            if ({g_done, g_busy, g_valid} !== 3'b0) begin
                n_errors++;
                $display("FAIL mid_quiet%0d: got done/busy/v=%b want 000", n, {g_done, g_busy, g_valid});
            end
        end
        g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        n_checks++;
        if ({g_valid, g_clr, g_busy} !== 3'b111 || {g_i, g_j, g_k, g_a, g_b, g_c} !== 192'b0) begin
            n_errors++;
            $display("FAIL mid_restart: got v/clr/busy=%b i%0d j%0d k%0d a%0d want 111 and zeros",
                     {g_valid, g_clr, g_busy}, g_i, g_j, g_k, g_a);
        end
        hit = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(negedge clk);
            if (g_done) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL mid_finish: done not seen, got %0d want 1", hit);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult_run(0);
        test_mult_run(1);
        test_mult_run(2);
        test_mult_run(2);
        test_bad_cfg();
        test_one();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mmul2_sequencer.md
# mmul2_sequencer

Loop-nest controller for the mmul2 multiply datapath. On `start` it walks the i/j/k index space of C[RA×CB] = A[RA×CA] · B[RB×CB], drives operand/result addresses and accumulator control into the MAC datapath, inserts one write-back cycle per output element, and pulses `done` after the last write. It replaces free-running index counters plus a separate end-of-loop detector with a single sequenced controller.

## Interface
- `RA`, default 0: rows of A (= rows of C)
- `CA`, default 0: columns of A (inner dimension)
- `RB`, default 0: rows of B; legal only when equal to CA
- `CB`, default 0: columns of B (= columns of C)
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  reset, asynchronous, active-low
- `start`  input  1  begin one full multiply; sampled only in IDLE
- `stall`  input  1  datapath back-pressure; freezes sequencing in RUN only
- `i`, `j`, `k`  output  32 each  current row / column / inner index
- `a_addr`  output  32  i*CA + k
- `b_addr`  output  32  k*CB + j
- `c_addr`  output  32  i*CB + j
- `valid`  output  1  i/j/k/a_addr/b_addr are a live MAC operand pair
- `acc_clr`  output  1  with `valid`, k==0: accumulator loads product instead of adding
- `c_we`  output  1  write accumulator to C at `c_addr`
- `busy`  output  1  high outside IDLE
- `done`  output  1  one-cycle completion pulse
- `err`  output  1  sticky config error, cleared by next accepted `start`

## Operation
- States: IDLE, RUN, WB, DONE. All outputs registered.
- Reset: state IDLE; all outputs 0 (indices and addresses included).
- IDLE: `start`=1 → RUN with i=j=k=0, addresses 0, `valid`=1, `acc_clr`=1, `err`=0. If CA≠RB or any of RA/CA/CB is 0: → DONE directly, `err`=1, no `valid`/`c_we` ever asserted.
- RUN, `stall`=1: all registers hold.
- RUN, `stall`=0, k<CA-1: k+1, a_addr+1, b_addr+CB, `acc_clr`=0.
- RUN, `stall`=0, k==CA-1: → WB; `valid`=0, `c_we`=1, c_addr=i*CB+j (held since RUN entry for this element).
- WB (one cycle, `stall` ignored): if j<CB-1 → RUN with j+1, k=0; else if i<RA-1 → RUN with i+1, j=0, k=0; else → DONE. RUN re-entry asserts `valid`, `acc_clr`.
- DONE: `done`=1, `busy`=0 next cycle; → IDLE. `start` in DONE ignored.
- `start` in RUN/WB ignored.
- Addresses maintained incrementally (adds only, no multipliers): on j advance a_addr=i*CA (row base, registered), b_addr=j+1, c_addr+1; on i advance a_addr=row base+CA, b_addr=0, c_addr+1.
- Arithmetic: 32-bit unsigned, wraps silently; products of parameters must fit 32 bits (elaboration-time assertion).
- Reset mid-operation: immediate return to IDLE, all outputs 0, no `done`.

## Timing
- Latency start→first `valid`: 1 cycle.
- Each output element: CA `valid` cycles + 1 WB cycle, plus stall cycles.
- Unstalled total start→`done`: RA*CB*(CA+1) + 1 cycles.
- Datapath contract: product for the operand pair presented with `valid` is accumulated by the cycle `c_we` is high; `c_we` follows the last `valid` of an element by exactly one cycle.
- `busy` rises the cycle after accepted `start`, falls the cycle after `done`.
- `done` never coincides with `c_we` or `valid`.

## Structure
- Shared package `mmul2_pkg`: state enum (IDLE/RUN/WB/DONE), `IDX_W`=32 constant, index/address typedef.
- One natural sub-module: `mmul2_idx_counter` — wrap counter with limit, enable, `last` flag; instanced for i, j, k. Address incrementers stay in the top.

## Test plan
- 2×3·3×2, no stall → 16 cycles busy before DONE; `valid` pattern 3 on/1 off ×4; `c_we` at c_addr 0,1,2,3; `done` at cycle 17 after start.
- Same config, `stall`=1 for 2 cycles at k=1 of element (1,0) → indices/addresses frozen, total extended by exactly 2 cycles, `c_we` count still 4.
- CA=3, RB=2 → `err`=1, `done` one cycle after start, zero `valid`/`c_we`; next `start` (still bad) keeps `err`=1.
- 1×1·1×1 → one `valid` with `acc_clr`=1, `c_we` next cycle at c_addr 0, `done` following; a_addr=b_addr=0.
- Reset asserted during WB of element (0,1) → all outputs 0 immediately, no `done`; fresh `start` restarts at i=j=k=0.
- `start` held high through run → no restart, single `done`; checker compares a/b/c_addr with i*CA+k, k*CB+j, i*CB+j every `valid`/`c_we` cycle.
